// File: rtl/ysyx_23060236_bus_arbiter_if.sv
// AXI4-Lite bundle: AR/R/AW/W/B channels for one link.
// master drives requests, slave drives readys and responses.
interface ysyx_23060236_bus_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   araddr;
  logic [2:0]          arsize;
  logic                arvalid;
  logic                arready;

  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  logic [ADDR_W-1:0]   awaddr;
  logic [2:0]          awsize;
  logic                awvalid;
  logic                awready;

  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;

  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;

  modport master (
    output araddr, arsize, arvalid,
    input  arready,
    input  rdata, rresp, rvalid,
    output rready,
    output awaddr, awsize, awvalid,
    input  awready,
    output wdata, wstrb, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready
  );

  modport slave (
    input  araddr, arsize, arvalid,
    output arready,
    output rdata, rresp, rvalid,
    input  rready,
    input  awaddr, awsize, awvalid,
    output awready,
    input  wdata, wstrb, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready
  );
endinterface

// File: rtl/ysyx_23060236_bus_arbiter.sv
// IFU/LSU to single AXI4-Lite port arbiter, one txn in flight.
// Ports: clock, reset (sync, low); ifu/lsu slave links; out master.
module ysyx_23060236_bus_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic clock,
  input  logic reset,
  ysyx_23060236_bus_arbiter_if.slave  ifu,
  ysyx_23060236_bus_arbiter_if.slave  lsu,
  ysyx_23060236_bus_arbiter_if.master out
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    IFU_R = 2'd1,
    LSU_R = 2'd2,
    LSU_W = 2'd3
  } state_e;

  state_e state, state_n;

  logic ar_done, ar_done_n;
  logic aw_done, aw_done_n;
  logic w_done,  w_done_n;
  logic last_lsu, last_lsu_n;

  logic              lsu_req;
  logic              ar_hs;
  logic              r_hs;
  logic              aw_hs;
  logic              w_hs;
  logic              b_ok;
  logic              b_hs;
  logic [ADDR_W-1:0] ar_addr;
  logic [DATA_W-1:0] r_data;

  // IFU never writes and has a fixed size.
  logic unused_ok;
  assign unused_ok = ^{ifu.arsize,
                       ifu.awaddr, ifu.awsize,
                       ifu.awvalid, ifu.wdata,
                       ifu.wstrb, ifu.wvalid,
                       ifu.bready};

  assign lsu_req = lsu.arvalid
                 | lsu.awvalid
                 | lsu.wvalid;

  assign ar_addr = (state == IFU_R)
                 ? ifu.araddr
                 : lsu.araddr;

  assign r_data = out.rdata;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state    <= IDLE;
      ar_done  <= 1'b0;
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
      last_lsu <= 1'b0;
    end else begin
      state    <= state_n;
      ar_done  <= ar_done_n;
      aw_done  <= aw_done_n;
      w_done   <= w_done_n;
      last_lsu <= last_lsu_n;
    end
  end

  always_comb begin
    state_n    = state;
    ar_done_n  = ar_done;
    aw_done_n  = aw_done;
    w_done_n   = w_done;
    last_lsu_n = last_lsu;

    ar_hs = 1'b0;
    r_hs  = 1'b0;
    aw_hs = 1'b0;
    w_hs  = 1'b0;
    b_ok  = aw_done & w_done;
    b_hs  = 1'b0;

    out.araddr  = ar_addr;
    out.arsize  = lsu.arsize;
    out.arvalid = 1'b0;
    out.rready  = 1'b0;
    out.awaddr  = lsu.awaddr;
    out.awsize  = lsu.awsize;
    out.awvalid = 1'b0;
    out.wdata   = lsu.wdata;
    out.wstrb   = lsu.wstrb;
    out.wvalid  = 1'b0;
    out.bready  = 1'b0;

    ifu.arready = 1'b0;
    ifu.rdata   = r_data;
    ifu.rresp   = out.rresp;
    ifu.rvalid  = 1'b0;
    ifu.awready = 1'b0;
    ifu.wready  = 1'b0;
    ifu.bresp   = 2'b00;
    ifu.bvalid  = 1'b0;

    lsu.arready = 1'b0;
    lsu.rdata   = r_data;
    lsu.rresp   = out.rresp;
    lsu.rvalid  = 1'b0;
    lsu.awready = 1'b0;
    lsu.wready  = 1'b0;
    lsu.bresp   = out.bresp;
    lsu.bvalid  = 1'b0;

    unique case (state)
      IDLE: begin
        // Round-robin only matters when both
        // masters contend; LSU read beats write.
        if (ifu.arvalid & lsu_req & last_lsu)
          state_n = IFU_R;
        else if (lsu.arvalid)
          state_n = LSU_R;
        else if (lsu.awvalid | lsu.wvalid)
          state_n = LSU_W;
        else if (ifu.arvalid)
          state_n = IFU_R;
      end

      IFU_R: begin
        out.arsize  = 3'b010;
        out.arvalid = ifu.arvalid & ~ar_done;
        ifu.arready = out.arready & ~ar_done;
        out.rready  = ifu.rready;
        ifu.rvalid  = out.rvalid;
        ar_hs = ifu.arvalid & ~ar_done
              & out.arready;
        r_hs  = out.rvalid & ifu.rready;
        if (ar_hs)
          ar_done_n = 1'b1;
        if (r_hs) begin
          state_n    = IDLE;
          ar_done_n  = 1'b0;
          last_lsu_n = 1'b0;
        end
      end

      LSU_R: begin
        out.arvalid = lsu.arvalid & ~ar_done;
        lsu.arready = out.arready & ~ar_done;
        out.rready  = lsu.rready;
        lsu.rvalid  = out.rvalid;
        ar_hs = lsu.arvalid & ~ar_done
              & out.arready;
        r_hs  = out.rvalid & lsu.rready;
        if (ar_hs)
          ar_done_n = 1'b1;
        if (r_hs) begin
          state_n    = IDLE;
          ar_done_n  = 1'b0;
          last_lsu_n = 1'b1;
        end
      end

      LSU_W: begin
        out.awvalid = lsu.awvalid & ~aw_done;
        lsu.awready = out.awready & ~aw_done;
        out.wvalid  = lsu.wvalid & ~w_done;
        lsu.wready  = out.wready & ~w_done;
        // B is only visible once both
        // request beats have been accepted.
        out.bready  = lsu.bready & b_ok;
        lsu.bvalid  = out.bvalid & b_ok;
        aw_hs = lsu.awvalid & ~aw_done
              & out.awready;
        w_hs  = lsu.wvalid & ~w_done
              & out.wready;
        b_hs  = out.bvalid & lsu.bready & b_ok;
        if (aw_hs)
          aw_done_n = 1'b1;
        if (w_hs)
          w_done_n = 1'b1;
        if (b_hs) begin
          state_n    = IDLE;
          aw_done_n  = 1'b0;
          w_done_n   = 1'b0;
          last_lsu_n = 1'b1;
        end
      end
    endcase
  end

endmodule

// File: tb/tb_ysyx_23060236_bus_arbiter.sv
// Directed bench for the IFU/LSU AXI4-Lite arbiter.
// Drives both masters and the downstream slave by hand.
module tb_ysyx_23060236_bus_arbiter;

  logic clock;
  logic reset;

  int n_chk;
  int n_fail;

  ysyx_23060236_bus_arbiter_if ifu_if ();
  ysyx_23060236_bus_arbiter_if lsu_if ();
  ysyx_23060236_bus_arbiter_if out_if ();

  ysyx_23060236_bus_arbiter dut (
    .clock (clock),
    .reset (reset),
    .ifu   (ifu_if),
    .lsu   (lsu_if),
    .out   (out_if)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h",
               tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    reset  = 1'b0;

    ifu_if.araddr  = '0;
    ifu_if.arsize  = 3'b010;
    ifu_if.arvalid = 1'b0;
    ifu_if.rready  = 1'b0;
    ifu_if.awaddr  = '0;
    ifu_if.awsize  = '0;
    ifu_if.awvalid = 1'b0;
    ifu_if.wdata   = '0;
    ifu_if.wstrb   = '0;
    ifu_if.wvalid  = 1'b0;
    ifu_if.bready  = 1'b0;

    lsu_if.araddr  = '0;
    lsu_if.arsize  = '0;
    lsu_if.arvalid = 1'b0;
    lsu_if.rready  = 1'b0;
    lsu_if.awaddr  = '0;
    lsu_if.awsize  = '0;
    lsu_if.awvalid = 1'b0;
    lsu_if.wdata   = '0;
    lsu_if.wstrb   = '0;
    lsu_if.wvalid  = 1'b0;
    lsu_if.bready  = 1'b0;

    out_if.arready = 1'b0;
    out_if.rdata   = '0;
    out_if.rresp   = '0;
    out_if.rvalid  = 1'b0;
    out_if.awready = 1'b0;
    out_if.wready  = 1'b0;
    out_if.bresp   = '0;
    out_if.bvalid  = 1'b0;

    // Reset state
    repeat (3) step();
    check_eq("rst_state", dut.state, 0);
    check_eq("rst_last", dut.last_lsu, 0);
    check_eq("rst_ardone", dut.ar_done, 0);
    check_eq("rst_arv", out_if.arvalid, 0);
    check_eq("rst_awv", out_if.awvalid, 0);
    check_eq("rst_wv", out_if.wvalid, 0);
    check_eq("rst_rrdy", out_if.rready, 0);
    check_eq("rst_brdy", out_if.bready, 0);
    reset = 1'b1;

    // IFU read alone
    ifu_if.araddr  = 32'h3000_0000;
    ifu_if.arvalid = 1'b1;
    ifu_if.rready  = 1'b1;
    #1;
    check_eq("t1_lat0", out_if.arvalid, 0);
    step();
    check_eq("t1_state", dut.state, 1);
    check_eq("t1_arv", out_if.arvalid, 1);
    check_eq("t1_addr", out_if.araddr,
             64'h3000_0000);
    check_eq("t1_size", out_if.arsize, 2);
    check_eq("t1_lsu_ardy", lsu_if.arready, 0);
    step();
    out_if.arready = 1'b1;
    #1;
    check_eq("t1_ardy", ifu_if.arready, 1);
    step();
    ifu_if.arvalid = 1'b0;
    out_if.arready = 1'b0;
    out_if.rvalid  = 1'b1;
    out_if.rdata   = 32'h0000_0413;
    out_if.rresp   = 2'b00;
    #1;
    check_eq("t1_arv_done", out_if.arvalid, 0);
    check_eq("t1_rv", ifu_if.rvalid, 1);
    check_eq("t1_rdata", ifu_if.rdata,
             64'h0000_0413);
    check_eq("t1_rrdy", out_if.rready, 1);
    step();
    out_if.rvalid = 1'b0;
    #1;
    check_eq("t1_idle", dut.state, 0);
    check_eq("t1_rv_off", ifu_if.rvalid, 0);

    // Simultaneous requests: LSU first
    ifu_if.araddr  = 32'h3000_0004;
    ifu_if.arvalid = 1'b1;
    lsu_if.araddr  = 32'h8000_0100;
    lsu_if.arsize  = 3'b000;
    lsu_if.arvalid = 1'b1;
    lsu_if.rready  = 1'b1;
    step();
    check_eq("t2_state", dut.state, 2);
    check_eq("t2_addr", out_if.araddr,
             64'h8000_0100);
    check_eq("t2_size", out_if.arsize, 0);
    out_if.arready = 1'b1;
    #1;
    check_eq("t2_lsu_ardy", lsu_if.arready, 1);
    check_eq("t2_ifu_ardy", ifu_if.arready, 0);
    step();
    lsu_if.arvalid = 1'b0;
    out_if.arready = 1'b0;
    out_if.rvalid  = 1'b1;
    out_if.rdata   = 32'h0000_0055;
    out_if.rresp   = 2'b11;
    #1;
    check_eq("t2_lsu_rv", lsu_if.rvalid, 1);
    check_eq("t2_ifu_rv", ifu_if.rvalid, 0);
    check_eq("t2_rdata", lsu_if.rdata, 64'h55);
    check_eq("t2_rresp", lsu_if.rresp, 2'b11);
    step();
    out_if.rvalid  = 1'b0;
    lsu_if.araddr  = 32'h8000_0104;
    lsu_if.arvalid = 1'b1;
    #1;
    check_eq("t2_last", dut.last_lsu, 1);
    step();
    check_eq("t2_rr_ifu", dut.state, 1);
    out_if.arready = 1'b1;
    #1;
    check_eq("t2b_ifu_ardy", ifu_if.arready, 1);
    check_eq("t2b_lsu_ardy", lsu_if.arready, 0);
    step();
    ifu_if.arvalid = 1'b0;
    out_if.arready = 1'b0;
    out_if.rvalid  = 1'b1;
    out_if.rresp   = 2'b00;
    #1;
    check_eq("t2b_ifu_rv", ifu_if.rvalid, 1);
    check_eq("t2b_lsu_rv", lsu_if.rvalid, 0);
    step();
    out_if.rvalid = 1'b0;
    step();
    check_eq("t2c_state", dut.state, 2);
    out_if.arready = 1'b1;
    step();
    lsu_if.arvalid = 1'b0;
    out_if.arready = 1'b0;
    out_if.rvalid  = 1'b1;
    step();
    out_if.rvalid = 1'b0;

    // LSU write, W before AW
    lsu_if.awaddr  = 32'h8000_0200;
    lsu_if.awsize  = 3'b010;
    lsu_if.awvalid = 1'b1;
    lsu_if.wdata   = 32'hDEAD_BEEF;
    lsu_if.wstrb   = 4'b1100;
    lsu_if.wvalid  = 1'b1;
    lsu_if.bready  = 1'b1;
    step();
    check_eq("t3_state", dut.state, 3);
    check_eq("t3_awv", out_if.awvalid, 1);
    check_eq("t3_wv", out_if.wvalid, 1);
    check_eq("t3_wdata", out_if.wdata,
             64'hDEAD_BEEF);
    check_eq("t3_wstrb", out_if.wstrb, 4'b1100);
    check_eq("t3_awaddr", out_if.awaddr,
             64'h8000_0200);
    check_eq("t3_rrdy", out_if.rready, 0);
    out_if.wready = 1'b1;
    #1;
    check_eq("t3_wrdy", lsu_if.wready, 1);
    check_eq("t3_awrdy0", lsu_if.awready, 0);
    step();
    lsu_if.wvalid = 1'b0;
    out_if.wready = 1'b0;
    out_if.bvalid = 1'b1;
    out_if.bresp  = 2'b10;
    #1;
    check_eq("t3_wv_done", out_if.wvalid, 0);
    check_eq("t3_brdy_early", out_if.bready, 0);
    check_eq("t3_bv_early", lsu_if.bvalid, 0);
    step();
    step();
    out_if.awready = 1'b1;
    #1;
    check_eq("t3_awrdy", lsu_if.awready, 1);
    check_eq("t3_brdy_aw", out_if.bready, 0);
    step();
    lsu_if.awvalid = 1'b0;
    out_if.awready = 1'b0;
    #1;
    check_eq("t3_awv_done", out_if.awvalid, 0);
    check_eq("t3_brdy", out_if.bready, 1);
    check_eq("t3_bv", lsu_if.bvalid, 1);
    check_eq("t3_bresp", lsu_if.bresp, 2'b10);
    step();
    out_if.bvalid = 1'b0;
    out_if.bresp  = 2'b00;
    #1;
    check_eq("t3_idle", dut.state, 0);
    check_eq("t3_flags",
             {dut.aw_done, dut.w_done}, 0);

    // IFU response backpressure
    ifu_if.araddr  = 32'h3000_0008;
    ifu_if.arvalid = 1'b1;
    ifu_if.rready  = 1'b0;
    step();
    check_eq("t5_state", dut.state, 1);
    out_if.arready = 1'b1;
    step();
    ifu_if.arvalid = 1'b0;
    out_if.arready = 1'b0;
    out_if.rvalid  = 1'b1;
    out_if.rdata   = 32'h0000_1234;
    for (int i = 0; i < 5; i++) begin
      #1;
      check_eq("t5_rrdy_lo", out_if.rready, 0);
      check_eq("t5_hold", dut.state, 1);
      step();
    end
    ifu_if.rready = 1'b1;
    #1;
    check_eq("t5_rrdy_hi", out_if.rready, 1);
    check_eq("t5_rdata", ifu_if.rdata, 64'h1234);
    step();
    out_if.rvalid = 1'b0;
    #1;
    check_eq("t5_idle", dut.state, 0);
    check_eq("t5_last", dut.last_lsu, 0);

    // LSU write then read, IFU pending
    ifu_if.araddr  = 32'h3000_0010;
    ifu_if.arvalid = 1'b1;
    lsu_if.awaddr  = 32'h8000_0300;
    lsu_if.awvalid = 1'b1;
    lsu_if.wdata   = 32'h1122_3344;
    lsu_if.wstrb   = 4'b1111;
    lsu_if.wvalid  = 1'b1;
    step();
    check_eq("t4_first_w", dut.state, 3);
    out_if.awready = 1'b1;
    out_if.wready  = 1'b1;
    step();
    lsu_if.awvalid = 1'b0;
    lsu_if.wvalid  = 1'b0;
    out_if.awready = 1'b0;
    out_if.wready  = 1'b0;
    out_if.bvalid  = 1'b1;
    lsu_if.araddr  = 32'h8000_0304;
    lsu_if.arsize  = 3'b010;
    lsu_if.arvalid = 1'b1;
    #1;
    check_eq("t4_both_done", lsu_if.bvalid, 1);
    check_eq("t4_ifu_ardy", ifu_if.arready, 0);
    step();
    out_if.bvalid = 1'b0;
    step();
    check_eq("t4_second_ifu", dut.state, 1);
    out_if.arready = 1'b1;
    step();
    ifu_if.arvalid = 1'b0;
    out_if.arready = 1'b0;
    out_if.rvalid  = 1'b1;
    step();
    out_if.rvalid = 1'b0;
    step();
    check_eq("t4_third_lsu", dut.state, 2);
    out_if.arready = 1'b1;
    step();
    lsu_if.arvalid = 1'b0;
    out_if.arready = 1'b0;
    out_if.rvalid  = 1'b1;
    out_if.rdata   = 32'h0000_0099;
    #1;
    check_eq("t4_rdata", lsu_if.rdata, 64'h99);
    step();
    out_if.rvalid = 1'b0;
    #1;
    check_eq("t4_idle", dut.state, 0);

    // Reset during LSU read
    lsu_if.araddr  = 32'h8000_0400;
    lsu_if.arvalid = 1'b1;
    step();
    out_if.arready = 1'b1;
    step();
    lsu_if.arvalid = 1'b0;
    out_if.arready = 1'b0;
    #1;
    check_eq("t6_ardone", dut.ar_done, 1);
    reset         = 1'b0;
    out_if.rvalid = 1'b1;
    step();
    check_eq("t6_state", dut.state, 0);
    check_eq("t6_ardone0", dut.ar_done, 0);
    check_eq("t6_arv", out_if.arvalid, 0);
    check_eq("t6_rrdy", out_if.rready, 0);
    check_eq("t6_lsu_rv", lsu_if.rvalid, 0);
    reset = 1'b1;
    #1;
    check_eq("t6_stray_lsu", lsu_if.rvalid, 0);
    check_eq("t6_stray_ifu", ifu_if.rvalid, 0);
    out_if.rvalid  = 1'b0;
    ifu_if.araddr  = 32'h3000_0020;
    ifu_if.arvalid = 1'b1;
    ifu_if.rready  = 1'b1;
    step();
    check_eq("t6_regrant", dut.state, 1);
    check_eq("t6_arv", out_if.arvalid, 1);
    check_eq("t6_addr", out_if.araddr,
             64'h3000_0020);
    out_if.arready = 1'b1;
    step();
    ifu_if.arvalid = 1'b0;
    out_if.arready = 1'b0;
    out_if.rvalid  = 1'b1;
    step();
    out_if.rvalid = 1'b0;
    #1;
    check_eq("t6_idle", dut.state, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
